// File: rtl/lns_add_pipe_if.sv
// Operand, result and table-load signals of the LNS adder pipeline.
// The master drives operands/table writes; the slave is the adder itself.
interface lns_add_pipe_if #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 9
);
    localparam int TADDR_W = (FRAC + 1 > WIDTH - 1 - FRAC) ? FRAC + 1 : WIDTH - 1 - FRAC;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               sx;
    logic               sy;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   z;
    logic               sz;
    logic               zero;
    logic               tbl_we;
    logic [1:0]         tbl_sel;
    logic [TADDR_W-1:0] tbl_addr;
    logic [WIDTH-1:0]   tbl_data;

    modport master (
        output in_valid, x, y, sx, sy, sub, out_ready,
               tbl_we, tbl_sel, tbl_addr, tbl_data,
        input  in_ready, out_valid, z, sz, zero
    );

    modport slave (
        input  in_valid, x, y, sx, sy, sub, out_ready,
               tbl_we, tbl_sel, tbl_addr, tbl_data,
        output in_ready, out_valid, z, sz, zero
    );
endinterface

// File: rtl/lns_add_pipe.sv
// Three-stage LNS adder/subtractor: Z = max(X,Y) + delta(|X-Y|), with loadable
// fine/coarse correction tables, zero detection, saturation and valid/ready.
module lns_add_pipe #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 9
) (
    input logic           clk,
    input logic           rst_n,
    lns_add_pipe_if.slave bus
);
    localparam int FW      = FRAC + 1;
    localparam int CW      = WIDTH - 1 - FRAC;
    localparam int FDEPTH  = 1 << FW;
    localparam int CDEPTH  = 1 << CW;
    localparam int TADDR_W = (FW > CW) ? FW : CW;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] fine_p   [FDEPTH];
    logic [WIDTH-1:0] fine_m   [FDEPTH];
    logic [WIDTH-1:0] coarse_p [CDEPTH];
    logic [WIDTH-1:0] coarse_m [CDEPTH];

    logic advance;
    logic accept;

    logic                 sye;
    logic                 same;
    logic                 gt;
    logic                 eq;
    logic                 clamp;
    logic                 fine_s;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] dabs;
    logic [WIDTH-1:0]     d;
    logic [TADDR_W-1:0]   idx;

    logic                 v1;
    logic [WIDTH-1:0]     m1;
    logic                 s1;
    logic                 zero1;
    logic                 same1;
    logic                 fine1;
    logic [TADDR_W-1:0]   idx1;

    logic                 v2;
    logic [WIDTH-1:0]     m2;
    logic                 s2;
    logic                 zero2;
    logic [WIDTH-1:0]     delta2;

    logic signed [WIDTH:0] sum;
    logic [WIDTH-1:0]     sat;

    logic fine_ok;
    logic coarse_ok;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && !bus.tbl_we && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        sye   = bus.sy ^ bus.sub;
        same  = (bus.sx == sye);
        gt    = $signed(bus.x) > $signed(bus.y);
        eq    = (bus.x == bus.y);
        diff  = $signed({bus.x[WIDTH-1], bus.x}) - $signed({bus.y[WIDTH-1], bus.y});
        dabs  = gt ? diff : -diff;
        clamp = dabs[WIDTH] | dabs[WIDTH-1];
        d     = clamp ? MAX_VAL : dabs[WIDTH-1:0];
        fine_s = (d[WIDTH-1:FW] == '0);
        idx   = fine_s ? TADDR_W'(d[FRAC:0]) : TADDR_W'(d[WIDTH-2:FRAC]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (advance) begin
            v1    <= accept;
            m1    <= gt ? bus.x : bus.y;
            s1    <= (gt || eq) ? bus.sx : sye;
            zero1 <= eq && !same;
            same1 <= same;
            fine1 <= fine_s;
            idx1  <= idx;
        end
    end

    // Synchronous table read; the write port below never shares a cycle with an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (advance) begin
            v2    <= v1;
            m2    <= m1;
            s2    <= s1;
            zero2 <= zero1;
            if (fine1) begin
                delta2 <= same1 ? fine_p[idx1[FW-1:0]] : fine_m[idx1[FW-1:0]];
            end else begin
                delta2 <= same1 ? coarse_p[idx1[CW-1:0]] : coarse_m[idx1[CW-1:0]];
            end
        end
    end

    always_comb begin
        sum = $signed({m2[WIDTH-1], m2}) + $signed({delta2[WIDTH-1], delta2});
        sat = sum[WIDTH-1:0];
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            sat = sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.z         <= '0;
            bus.sz        <= 1'b0;
            bus.zero      <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= v2;
            if (zero2) begin
                bus.z    <= MIN_VAL;
                bus.sz   <= 1'b0;
                bus.zero <= 1'b1;
            end else begin
                bus.z    <= sat;
                bus.sz   <= s2;
                bus.zero <= 1'b0;
            end
        end
    end

    assign fine_ok   = ((bus.tbl_addr >> FW) == '0);
    assign coarse_ok = ((bus.tbl_addr >> CW) == '0);

    // Table contents are deliberately not reset so they survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (bus.tbl_we) begin
            unique case (bus.tbl_sel)
                2'd0: if (fine_ok)   fine_p[bus.tbl_addr[FW-1:0]]   <= bus.tbl_data;
                2'd1: if (fine_ok)   fine_m[bus.tbl_addr[FW-1:0]]   <= bus.tbl_data;
                2'd2: if (coarse_ok) coarse_p[bus.tbl_addr[CW-1:0]] <= bus.tbl_data;
                2'd3: if (coarse_ok) coarse_m[bus.tbl_addr[CW-1:0]] <= bus.tbl_data;
            endcase
        end
    end
endmodule

// File: tb/tb_lns_add_pipe.sv
// Scoreboard bench for lns_add_pipe: expected results come from an integer
// model of max(X,Y) + delta(|X-Y|) and are popped by an independent monitor.
module tb_lns_add_pipe;
    localparam int W    = 18;
    localparam int F    = 9;
    localparam int TA   = (F + 1 > W - 1 - F) ? F + 1 : W - 1 - F;
    localparam int FD   = 1 << (F + 1);
    localparam int CD   = 1 << (W - 1 - F);
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lns_add_pipe_if #(.WIDTH(W), .FRAC(F)) bus ();

    lns_add_pipe #(.WIDTH(W), .FRAC(F)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tbl_fp [FD];
    int tbl_fm [FD];
    int tbl_cp [CD];
    int tbl_cm [CD];

    logic [W+1:0] exp_q [$];
    int n_compared   = 0;
    int n_mismatched = 0;

    logic         stall_prev = 1'b0;
    logic [W+1:0] held_out;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result packed as {z, sz, zero}.
    function automatic logic [W+1:0] model(input int xi, input int yi, input bit sxi,
                                          input bit syi, input bit subi);
        bit sye;
        bit same;
        bit s;
        int d;
        int m;
        int delta;
        int r;
        logic [W-1:0] zr;
        sye  = syi ^ subi;
        same = (sxi == sye);
        if (xi == yi && !same) begin
            zr = W'(MINV);
            return {zr, 1'b0, 1'b1};
        end
        d = (xi > yi) ? xi - yi : yi - xi;
        if (d > MAXV) d = MAXV;
        m = (xi > yi) ? xi : yi;
        s = (xi < yi) ? sye : sxi;
        if (d < FD) delta = same ? tbl_fp[d] : tbl_fm[d];
        else        delta = same ? tbl_cp[d / (1 << F)] : tbl_cm[d / (1 << F)];
        r = m + delta;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        zr = W'(r);
        return {zr, s, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_table(input int sel, input int addr, input int val);
        bus.tbl_we   = 1'b1;
        bus.tbl_sel  = 2'(sel);
        bus.tbl_addr = TA'(addr);
        bus.tbl_data = W'(val);
        tick();
        bus.tbl_we = 1'b0;
        case (sel)
            0: if (addr < FD) tbl_fp[addr] = val;
            1: if (addr < FD) tbl_fm[addr] = val;
            2: if (addr < CD) tbl_cp[addr] = val;
            default: if (addr < CD) tbl_cm[addr] = val;
        endcase
    endtask

    task automatic applyStimulus(input int xi, input int yi, input bit sxi,
                                 input bit syi, input bit subi);
        logic accepted;
        accepted   = 1'b0;
        bus.x      = W'(xi);
        bus.y      = W'(yi);
        bus.sx     = sxi;
        bus.sy     = syi;
        bus.sub    = subi;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(model(xi, yi, sxi, syi, subi));
                accepted = 1'b1;
            end
            tick();
            if (accepted) break;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic int rand_val();
        return int'($urandom_range(0, 2 * MAXV + 1)) + MINV;
    endfunction

    // Monitor: pops the scoreboard on every transfer and checks the hold rule while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("hold_result", 32'({bus.z, bus.sz, bus.zero}), 32'(held_out));
                end
                if (bus.out_valid === 1'b1) begin
                    if (bus.out_ready === 1'b0) begin
                        checkOutput("in_ready_stalled", 32'(bus.in_ready), 32'd0);
                    end else if (exp_q.size() == 0) begin
                        checkOutput("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        checkOutput("result", 32'({bus.z, bus.sz, bus.zero}), 32'(exp_q.pop_front()));
                    end
                end
                stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
                held_out   = {bus.z, bus.sz, bus.zero};
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bp_x [6];
        int bp_y [6];
        bit rnd_done;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.sx        = 1'b0;
        bus.sy        = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        bus.tbl_we    = 1'b0;
        bus.tbl_sel   = '0;
        bus.tbl_addr  = '0;
        bus.tbl_data  = '0;
        rst_n         = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_outputs", 32'({bus.z, bus.sz, bus.zero}), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_cycle_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < ((s < 2) ? FD : CD); a++) begin
                write_table(s, a, int'($urandom_range(0, 1200)) - 600);
            end
        end

        $display("[TB] directed operands");
        write_table(0, 0, 512);
        applyStimulus(512, 512, 0, 0, 0);
        write_table(3, 3, -25);
        applyStimulus(2048, 512, 0, 0, 1);
        applyStimulus(700, 700, 0, 1, 0);
        applyStimulus(700, 900, 0, 1, 0);
        write_table(0, 71, 300);
        applyStimulus(131071, 131000, 0, 0, 0);
        write_table(2, 255, -5);
        applyStimulus(131071, -131072, 0, 0, 0);
        write_table(1, 72, -500);
        applyStimulus(-131000, -131072, 0, 1, 0);
        applyStimulus(5000, 3977, 1, 1, 0);
        applyStimulus(5000, 3976, 1, 0, 1);
        write_table(2, 44, 123);
        write_table(2, 300, 777);
        applyStimulus(44 * 512 + 100, 100, 0, 0, 0);
        drain();

        $display("[TB] back-pressure");
        for (int i = 0; i < 6; i++) begin
            bp_x[i] = rand_val();
            bp_y[i] = bp_x[i] + int'($urandom_range(0, 4000)) - 2000;
            if (bp_y[i] > MAXV) bp_y[i] = MAXV;
            if (bp_y[i] < MINV) bp_y[i] = MINV;
        end
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(bp_x[i], bp_y[i], i[0], i[1], i[2]);
            end
            begin
                repeat (3) tick();
                bus.out_ready = 1'b0;
                repeat (3) tick();
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] write collision");
        bus.x        = W'(1000);
        bus.y        = W'(1005);
        bus.sx       = 1'b0;
        bus.sy       = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        bus.tbl_we   = 1'b1;
        bus.tbl_sel  = 2'd0;
        bus.tbl_addr = TA'(5);
        bus.tbl_data = W'(77);
        @(negedge clk);
        checkOutput("collide_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.tbl_we = 1'b0;
        tbl_fp[5]  = 77;
        applyStimulus(1000, 1005, 0, 0, 0);
        drain();

        $display("[TB] reset mid-stream");
        bus.out_ready = 1'b0;
        applyStimulus(rand_val(), rand_val(), 0, 0, 0);
        applyStimulus(rand_val(), rand_val(), 1, 0, 0);
        applyStimulus(rand_val(), rand_val(), 0, 1, 1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_outputs", 32'({bus.z, bus.sz, bus.zero}), 32'd0);
        tick();
        bus.out_ready = 1'b1;
        applyStimulus(512, 512, 0, 0, 0);
        applyStimulus(2048, 512, 0, 0, 1);
        drain();

        $display("[TB] random operands");
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    int xi;
                    int yi;
                    xi = rand_val();
                    case ($urandom_range(0, 3))
                        0: yi = xi;
                        1: begin
                            yi = xi + int'($urandom_range(0, 4000)) - 2000;
                            if (yi > MAXV) yi = MAXV;
                            if (yi < MINV) yi = MINV;
                        end
                        default: yi = rand_val();
                    endcase
                    applyStimulus(xi, yi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) tick();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/lns_add_pipe.md
# lns_add_pipe

Pipelined, parametrised log-number-system (LNS) adder/subtractor, the successor to the single-cycle non-uniform-LUT log adder. Computes Z = max(X,Y) + Δ±(|X−Y|). Δ comes from runtime-loadable fine (|d|<2) and coarse (|d|≥2) tables. Adds an explicit subtract mode, exact-zero detection, output saturation and valid/ready flow control. Sits in the LNS datapath between operand sequencers and downstream LNS multiply/accumulate stages.

## Interface
- WIDTH, 18, signed log-magnitude width (fixed point)
- FRAC, 9, fractional bits of X/Y/Z/table entries
- TADDR_W, max(FRAC+1, WIDTH−1−FRAC), table write address width (derived; do not override)
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid & in_ready
- x, y  in  WIDTH each  signed log magnitudes
- sx, sy  in  1 each  operand signs (1 = negative)
- sub  in  1  1: compute X − Y (effective sy = ~sy)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- z  out  WIDTH  signed log magnitude of result
- sz  out  1  result sign
- zero  out  1  exact-zero result (−∞ in log domain)
- tbl_we  in  1  table write strobe
- tbl_sel  in  2  0 fine Δ+, 1 fine Δ−, 2 coarse Δ+, 3 coarse Δ−
- tbl_addr  in  TADDR_W  entry index
- tbl_data  in  WIDTH  signed entry value

## Operation
- Effective sign: sye = sy ^ sub; same = (sx == sye).
- Stage 1 (S1): d = |x − y| computed in WIDTH+1 bits. Clamp d to 2^(WIDTH−1)−1. m = (x > y) ? x : y. s = (x > y) ? sx : sye. If x == y, s = sx. Fine segment when d[WIDTH−1:FRAC+1] == 0, with index d[FRAC:0]. Otherwise coarse segment, with index d[WIDTH−2:FRAC]. Coarse indices 0 and 1 are unused.
- Zero flag in S1: x == y and !same.
- Stage 2 (S2): synchronous table read. Select Δ+ when same, Δ− otherwise.
- Table depths:
  - fine: 2^(FRAC+1) (1024 at defaults)
  - coarse: 2^(WIDTH−1−FRAC) (256 at defaults)
- Stage 3 (S3): r = m + Δ, computed in WIDTH+1 bits. Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- If zero is set: z = −2^(WIDTH−1), sz = 0, zero = 1, and the table value is ignored.
- Table writes:
  - Take effect on the clock edge.
  - Writes with tbl_addr ≥ depth of the selected table are ignored.
  - Contents are not reset and are undefined until loaded.
- Simultaneous tbl_we and in_valid: the write wins and in_ready = 0 that cycle. No lookup is ever issued in the same cycle as a write.

## Timing
- Latency is 3 cycles from accept to out_valid. Throughput is 1 per cycle with no back-pressure.
- advance = !out_valid | out_ready. All stages shift together when advance is 1 and hold when it is 0.
- Bubbles collapse only through the whole-pipe shift; stages are not independently compressed.
- in_ready = advance & !tbl_we & rst_n (combinational).
- Output hold rule: z, sz and zero are held stable while out_valid & !out_ready.
- Reset, synchronous while rst_n = 0:
  - all stage valids, out_valid, z, sz and zero go to 0
  - in-flight operands are discarded, including on reset mid-stream
  - table contents are retained
- First accept is possible in the first cycle with rst_n = 1.
- A table write at edge k affects operands accepted at edge ≥ k+1.

## Test plan
- Fine, same sign: load fine Δ+[0] = 512 (1.0). Apply x = y = 512 (1.0), sx = sy = 0 → after 3 cycles z = 1024, sz = 0, zero = 0.
- Coarse, subtract mode: load coarse Δ−[3] = −25. Apply x = 2048 (4.0), y = 512, sx = sy = 0, sub = 1 → d = 1536 (coarse idx 3), z = 2023, sz = 0.
- Sign and zero: apply x = y = 700, sx = 0, sy = 1 → zero = 1, z = −131072, sz = 0. Then swap magnitudes with y = 900, sx = 0, sy = 1 → sz = 1, z = 900 + Δ−(200).
- Saturation: x = 131071, y = 131000, Δ+ entry = 300 → z = 131071. Clamp check: x = 131071, y = −131072 → d clamped and coarse idx 255 used.
- Back-pressure: 6 back-to-back operands with out_ready low on cycles 4–6 → no loss or duplication, order preserved, z stable while stalled, in_ready low while the pipe is full.
- Write collision and reset: assert tbl_we with in_valid → no accept that cycle. Pulse rst_n low for 1 cycle with 3 operands in flight → out_valid = 0 next cycle and the tables still return the previously loaded values.
